lcd_frame_copier: RTL and testbench

LCD_FRAME_COPIER -- requirements
Module: lcd_frame_copier

---
 rtl/lcd_frame_copier.sv | 153 +++++++++++++++
 tb/tb_lcd_frame_copier.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_copier.sv
// lcd_frame_copier: copies a paged framebuffer to an LCD controller over a
// shared bus. Each page gets a page-select and two column-reset commands,
// then COLUMNS data bytes. Every bus access is a WR cycle followed by a GAP.
module lcd_frame_copier #(
    parameter int          COLUMNS   = 96,
    parameter int          PAGES     = 8,
    parameter logic [23:0] CMD_ADDR  = 24'h20FE,
    parameter logic [23:0] DATA_ADDR = 24'h20FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_ce,
    input  logic        start,
    input  logic        bus_grant,
    input  logic [7:0]  fb_data,
    output logic        busy,
    output logic        done,
    output logic        bus_req,
    output logic        bus_write,
    output logic [23:0] address_out,
    output logic [7:0]  data_out,
    output logic [9:0]  fb_addr
);

    typedef enum logic [2:0] {
        IDLE, REQ, CMD_PAGE, CMD_COLLO, CMD_COLHI, DATA, FINISH
    } state_t;

    typedef enum logic {WR, GAP} phase_t;

    localparam logic [6:0] COL_LAST  = 7'(COLUMNS - 1);
    localparam logic [3:0] PAGE_LAST = 4'(PAGES - 1);

    state_t      state, state_n;
    phase_t      phase, phase_n;
    logic [3:0]  page, page_n;
    logic [6:0]  column, column_n;
    logic [23:0] address_n;
    logic [7:0]  data_n;
    logic [9:0]  fb_addr_n;

    function automatic logic [9:0] fb_index(input logic [3:0] pg, input logic [6:0] col);
        return 10'(int'(pg) * COLUMNS + int'(col));
    endfunction

    // State, counters and bus/framebuffer registers; advance only on clk_ce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= WR;
            page        <= '0;
            column      <= '0;
            address_out <= '0;
            data_out    <= '0;
            fb_addr     <= '0;
        end else if (clk_ce) begin
            state       <= state_n;
            phase       <= phase_n;
            page        <= page_n;
            column      <= column_n;
            address_out <= address_n;
            data_out    <= data_n;
            fb_addr     <= fb_addr_n;
        end
    end

    // Next state, counter updates and the values loaded on entry to each WR.
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        page_n    = page;
        column_n  = column;
        address_n = address_out;
        data_n    = data_out;
        fb_addr_n = fb_addr;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n  = REQ;
                    page_n   = '0;
                    column_n = '0;
                end
            end
            REQ: begin
                if (bus_grant) begin
                    state_n   = CMD_PAGE;
                    phase_n   = WR;
                    address_n = CMD_ADDR;
                    data_n    = 8'hB0 | {4'h0, page};
                end
            end
            CMD_PAGE, CMD_COLLO, CMD_COLHI, DATA: begin
                if (phase == WR) begin
                    phase_n = GAP;
                    // fb_addr moves to the next data byte when a GAP begins so the
                    // framebuffer has the whole GAP to return it before capture.
                    if (state != DATA)
                        fb_addr_n = fb_index(page, column);
                    else if (column != COL_LAST)
                        fb_addr_n = fb_index(page, column + 7'd1);
                    else if (page != PAGE_LAST)
                        fb_addr_n = fb_index(page + 4'd1, '0);
                end else if (bus_grant) begin
                    phase_n = WR;
                    case (state)
                        CMD_PAGE: begin
                            state_n   = CMD_COLLO;
                            address_n = CMD_ADDR;
                            data_n    = 8'h00;
                        end
                        CMD_COLLO: begin
                            state_n   = CMD_COLHI;
                            address_n = CMD_ADDR;
                            data_n    = 8'h10;
                        end
                        CMD_COLHI: begin
                            state_n   = DATA;
                            address_n = DATA_ADDR;
                            data_n    = fb_data;
                        end
                        default: begin
                            if (column != COL_LAST) begin
                                column_n  = column + 7'd1;
                                address_n = DATA_ADDR;
                                data_n    = fb_data;
                            end else if (page != PAGE_LAST) begin
                                column_n  = '0;
                                page_n    = page + 4'd1;
                                state_n   = CMD_PAGE;
                                address_n = CMD_ADDR;
                                data_n    = 8'hB0 | {4'h0, page + 4'd1};
                            end else begin
                                state_n = FINISH;
                                phase_n = GAP;
                            end
                        end
                    endcase
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Status and strobe outputs decoded from state and phase.
    always_comb begin
        busy      = (state != IDLE) && (state != FINISH);
        done      = (state == FINISH);
        bus_req   = busy;
        bus_write = busy && (state != REQ) && (phase == WR);
    end

endmodule

// File: tb/tb_lcd_frame_copier.sv
// Bench for lcd_frame_copier: framebuffer model with one-clock read latency,
// an expected-write scoreboard built from the page/command/data rules, and a
// small LCD model that tracks page/column commands and stores data bytes.
module tb_lcd_frame_copier;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_ce = 1'b1;
    logic        start;
    logic        bus_grant;
    logic [7:0]  fb_data = '0;
    logic        busy, done, bus_req, bus_write;
    logic [23:0] address_out;
    logic [7:0]  data_out;
    logic [9:0]  fb_addr;

    lcd_frame_copier #(
        .COLUMNS  (96),
        .PAGES    (8),
        .CMD_ADDR (24'h20FE),
        .DATA_ADDR(24'h20FF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_ce     (clk_ce),
        .start      (start),
        .bus_grant  (bus_grant),
        .fb_data    (fb_data),
        .busy       (busy),
        .done       (done),
        .bus_req    (bus_req),
        .bus_write  (bus_write),
        .address_out(address_out),
        .data_out   (data_out),
        .fb_addr    (fb_addr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // clock-enable generator: one enabled edge every ce_div clocks
    int ce_div = 1;
    int ce_cnt = 0;
    always @(negedge clk) begin
        ce_cnt = (ce_cnt + 1) % ce_div;
        clk_ce = (ce_cnt == 0);
    end

    // framebuffer: read data follows fb_addr one clock later
    logic [7:0] fb_mem [0:1023];
    always @(posedge clk) begin
        #1;
        fb_data = fb_mem[fb_addr];
    end

    logic [31:0] expq[$];
    logic [31:0] wlog[$];
    logic [7:0]  dlog[$];
    int frame_len, writes_total, data_writes, done_pulses;
    int clk_n = 0, t_first, t_done, bw_len = 0, done_len = 0;
    logic prev_bw = 1'b0, prev_done = 1'b0;
    logic [7:0] lcd [0:7][0:127];
    int lcd_page, lcd_col;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic setup_frame(input logic [7:0] key);
        for (int unsigned i = 0; i < 1024; i++) fb_mem[i] = 8'(i) ^ key;
        expq.delete();
        wlog.delete();
        dlog.delete();
        writes_total = 0;
        data_writes  = 0;
        done_pulses  = 0;
        t_first      = 0;
        t_done       = 0;
        lcd_page     = 0;
        lcd_col      = 0;
        for (int unsigned p = 0; p < 8; p++) begin
            expq.push_back({24'h20FE, 8'hB0 | 8'(p)});
            expq.push_back({24'h20FE, 8'h00});
            expq.push_back({24'h20FE, 8'h10});
            for (int unsigned c = 0; c < 96; c++)
                expq.push_back({24'h20FF, fb_mem[p * 96 + c]});
        end
        frame_len = expq.size();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        repeat (ce_div) @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_data(input int n, input int budget, input string name);
        int k = 0;
        while (data_writes < n && k < budget) begin
            tick();
            k++;
        end
        check(name, 32'(data_writes >= n), 32'd1);
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (done_pulses == 0 && k < budget) begin
            tick();
            k++;
        end
        check(name, 32'(done_pulses > 0), 32'd1);
    endtask

    // compare process: every write strobe against the scoreboard, strobe widths,
    // done pulses, and the LCD model
    always @(negedge clk) begin
        logic [31:0] exp_w;
        clk_n++;
        if (reset) begin
            prev_bw   = 1'b0;
            prev_done = 1'b0;
            bw_len    = 0;
            done_len  = 0;
        end else begin
            if (bus_write) begin
                bw_len++;
                if (!prev_bw) begin
                    writes_total++;
                    if (writes_total == 1) t_first = clk_n;
                    wlog.push_back({address_out, data_out});
                    if (expq.size() == 0) begin
                        check("extra_write", 32'(writes_total), 32'(frame_len));
                    end else begin
                        exp_w = expq.pop_front();
                        check("write", {address_out, data_out}, exp_w);
                    end
                    if (address_out == 24'h20FE) begin
                        if (data_out[7:4] == 4'hB)
                            lcd_page = int'(data_out[3:0]);
                        else if (data_out[7:4] == 4'h0)
                            lcd_col = (lcd_col & 'hF0) | int'(data_out[3:0]);
                        else if (data_out[7:4] == 4'h1)
                            lcd_col = (lcd_col & 'h0F) | (int'(data_out[3:0]) << 4);
                    end else if (address_out == 24'h20FF) begin
                        if (lcd_page < 8 && lcd_col < 128) lcd[lcd_page][lcd_col] = data_out;
                        lcd_col++;
                        data_writes++;
                        dlog.push_back(data_out);
                    end
                end
            end else if (prev_bw) begin
                check("wr_width", 32'(bw_len), 32'(ce_div));
                bw_len = 0;
            end
            if (done) begin
                done_len++;
                if (!prev_done) begin
                    done_pulses++;
                    t_done = clk_n;
                end
            end else if (prev_done) begin
                check("done_width", 32'(done_len), 32'(ce_div));
                done_len = 0;
            end
            prev_bw   = bus_write;
            prev_done = done;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1);
    end

    initial begin
        int hold_w;
        int k;
        reset     = 1'b1;
        start     = 1'b0;
        bus_grant = 1'b1;
        setup_frame(8'h00);
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_write", 32'(bus_write), 32'd0);
        check("rst_address", 32'(address_out), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // frame A: continuous enable and grant, second start mid-frame
        setup_frame(8'h00);
        pulse_start();
        wait_data(400, 3000, "a_reach_mid");
        pulse_start();
        wait_done(4000, "a_done_seen");
        check("a_w0", wlog[0], 32'h20FE_B0);
        check("a_w1", wlog[1], 32'h20FE_00);
        check("a_w2", wlog[2], 32'h20FE_10);
        check("a_w3", wlog[3], 32'h20FF_00);
        check("a_w98", wlog[98], 32'h20FF_5F);
        check("a_w99", wlog[99], 32'h20FE_B1);
        check("a_writes", 32'(writes_total), 32'd792);
        check("a_data_writes", 32'(data_writes), 32'd768);
        check("a_exp_left", 32'(expq.size()), 32'd0);
        check("a_ce_cycles", 32'((t_done - t_first) / ce_div), 32'd1584);
        check("a_lcd_p7c95", 32'(lcd[7][95]), 32'h0000_00FF);
        for (int unsigned p = 0; p < 8; p++)
            check("a_lcd_col95", 32'(lcd[p][95]), 32'(fb_mem[p * 96 + 95]));
        repeat (20) tick();
        check("a_idle_busy", 32'(busy), 32'd0);
        check("a_single_done", 32'(done_pulses), 32'd1);
        check("a_no_restart", 32'(writes_total), 32'd792);

        // frame B: grant withdrawn after the 50th data write
        setup_frame(8'h5A);
        pulse_start();
        wait_data(50, 3000, "b_reach_50");
        bus_grant = 1'b0;
        hold_w = writes_total;
        for (int unsigned i = 0; i < 10; i++) begin
            tick();
            check("b_hold_no_write", 32'(bus_write), 32'd0);
        end
        check("b_hold_count", 32'(writes_total), 32'(hold_w));
        bus_grant = 1'b1;
        wait_done(4000, "b_done_seen");
        check("b_data51", 32'(dlog[50]), 32'h0000_0068);
        check("b_writes", 32'(writes_total), 32'd792);
        check("b_exp_left", 32'(expq.size()), 32'd0);
        check("b_single_done", 32'(done_pulses), 32'd1);
        repeat (5) tick();

        // frame C: clock enable on every third clock
        ce_div = 3;
        repeat (6) tick();
        setup_frame(8'hC3);
        pulse_start();
        wait_done(10000, "c_done_seen");
        check("c_writes", 32'(writes_total), 32'd792);
        check("c_exp_left", 32'(expq.size()), 32'd0);
        check("c_ce_cycles", 32'((t_done - t_first) / ce_div), 32'd1584);
        check("c_single_done", 32'(done_pulses), 32'd1);
        check("c_w0", wlog[0], 32'h20FE_B0);
        repeat (9) tick();
        ce_div = 1;
        repeat (4) tick();

        // frame D: reset during page 3, then restart
        setup_frame(8'h11);
        pulse_start();
        k = 0;
        while (!(data_writes >= 300 && bus_write) && k < 3000) begin
            tick();
            k++;
        end
        check("d_reach_page3", 32'(data_writes >= 300 && bus_write), 32'd1);
        reset = 1'b1;
        #1;
        check("d_rst_bus_write", 32'(bus_write), 32'd0);
        check("d_rst_bus_req", 32'(bus_req), 32'd0);
        check("d_rst_busy", 32'(busy), 32'd0);
        check("d_rst_address", 32'(address_out), 32'd0);
        check("d_rst_fb_addr", 32'(fb_addr), 32'd0);
        hold_w = writes_total;
        repeat (3) tick();
        check("d_rst_no_write", 32'(writes_total), 32'(hold_w));
        reset = 1'b0;
        repeat (2) tick();
        setup_frame(8'h11);
        pulse_start();
        wait_done(4000, "d_done_seen");
        check("d_restart_w0", wlog[0], 32'h20FE_B0);
        check("d_restart_w3", wlog[3], 32'h20FF_11);
        check("d_writes", 32'(writes_total), 32'd792);
        check("d_exp_left", 32'(expq.size()), 32'd0);
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
